// File: rtl/seq_det_pkg.sv
// Shared constants and the overlap-mode encoding for the serial pattern detector.
// Match counter is built only when SEQ_DET_CNT_EN is defined (see seq_det_param).
package seq_det_pkg;

  typedef enum logic {
    OVL_NONE = 1'b0,
    OVL_ON   = 1'b1
  } ovl_mode_e;

  localparam int                   SEQ_W_DEF   = 4;
  localparam logic [SEQ_W_DEF-1:0] SEQ_PAT_DEF = 4'b1011;
  localparam int                   SEQ_CW_DEF  = 8;

endpackage

// File: rtl/seq_det_shreg.sv
// History and fill tracking for seq_det_param. Only the newest W-1 bits are kept:
// the oldest bit of a W-bit window is always shifted out before it could be compared.
module seq_det_shreg
  import seq_det_pkg::*;
#(
  parameter int W  = SEQ_W_DEF,
  parameter int FW = $clog2(SEQ_W_DEF + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_acc,
  input  logic          i_bit,
  input  logic          i_match,
  input  ovl_mode_e     i_mode,
  output logic [W-2:0]  o_hist,
  output logic [FW-1:0] o_fill
);

  logic [W-2:0]  r_hist;
  logic [FW-1:0] r_fill;

  generate
    if (W == 2) begin : g_hist1
      always_ff @(posedge clk) begin
        if (rst || i_load) r_hist <= '0;
        else if (i_acc)    r_hist <= i_bit;
      end
    end else begin : g_histn
      always_ff @(posedge clk) begin
        if (rst || i_load) r_hist <= '0;
        else if (i_acc)    r_hist <= {r_hist[W-3:0], i_bit};
      end
    end
  endgenerate

  // A non-overlapping match consumes every bit seen so far; otherwise fill saturates at W.
  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_fill <= '0;
    end else if (i_acc) begin
      if (i_match && (i_mode == OVL_NONE)) r_fill <= '0;
      else if (r_fill != FW'(W))           r_fill <= r_fill + FW'(1);
    end
  end

  assign o_hist = r_hist;
  assign o_fill = r_fill;

endmodule

// File: rtl/seq_det_param.sv
// Parameterised serial pattern detector: one-cycle registered match pulse, optional
// overlap, runtime pattern load. Saturating match counter present when SEQ_DET_CNT_EN is defined.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int           W       = SEQ_W_DEF,
  parameter logic [W-1:0] PAT_RST = SEQ_PAT_DEF,
  parameter int           CW      = SEQ_CW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in,
  input  logic         ovl,
  input  logic         pat_load,
  input  logic [W-1:0] pat_in,
  output logic         out
`ifdef SEQ_DET_CNT_EN
  ,
  input  logic         cnt_clr,
  output logic [CW-1:0] match_cnt
`endif
);

  localparam int FW = $clog2(W + 1);

  logic [W-1:0]  r_pat;
  logic          r_match_p1;
  logic [W-2:0]  w_hist;
  logic [FW-1:0] w_fill;
  logic          w_acc;
  logic          w_match;
  ovl_mode_e     w_mode;

  // A bit arriving together with a pattern load is dropped.
  assign w_acc   = in_valid && !pat_load;
  assign w_mode  = ovl_mode_e'(ovl);
  assign w_match = w_acc && (w_fill >= FW'(W - 1)) && ({w_hist, in} == r_pat);

  seq_det_shreg #(
    .W  (W),
    .FW (FW)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (pat_load),
    .i_acc   (w_acc),
    .i_bit   (in),
    .i_match (w_match),
    .i_mode  (w_mode),
    .o_hist  (w_hist),
    .o_fill  (w_fill)
  );

  always_ff @(posedge clk) begin
    if (rst)           r_pat <= PAT_RST;
    else if (pat_load) r_pat <= pat_in;
  end

  // Stage p1: registered match pulse
  always_ff @(posedge clk) begin
    if (rst) r_match_p1 <= 1'b0;
    else     r_match_p1 <= w_match;
  end

  assign out = r_match_p1;

`ifdef SEQ_DET_CNT_EN
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)                              r_cnt <= '0;
    else if (cnt_clr)                     r_cnt <= '0;
    else if (w_match && (r_cnt != '1))    r_cnt <= r_cnt + CW'(1);
  end

  assign match_cnt = r_cnt;
`endif

endmodule

// File: doc/seq_det_param.md
SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 SHALL have parameter W, default 4: pattern length in bits, legal range 2..32.
REQ-002 SHALL have parameter PAT_RST, default 4'b1011: pattern loaded at reset, W bits wide.
REQ-003 SHALL have parameter CW, default 8: width of the match counter.
REQ-004 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: qualifies in; bit is accepted only when high.
REQ-007 SHALL have port in, input, 1 bit: serial data bit, newest bit last.
REQ-008 SHALL have port ovl, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port pat_load, input, 1 bit: loads pat_in as the new pattern.
REQ-010 SHALL have port pat_in, input, W bits: new pattern; the MSB is compared against the oldest bit.
REQ-011 SHALL have port cnt_clr, input, 1 bit: clears the match counter.
REQ-012 SHALL have port out, output, 1 bit: registered one-cycle match pulse.
REQ-013 SHALL have port match_cnt, output, CW bits: saturating match count (present only per REQ-026).

Function
REQ-014 SHALL, on an accepted bit, shift in into a W-bit history register and increment the fill count, saturating at W.
REQ-015 SHALL detect a match when {history[W-2:0], in} equals the pattern, fill >= W-1 and the bit is accepted.
REQ-016 SHALL assert out in the cycle after the completing bit is accepted, for exactly one cycle; out SHALL be 0 in every other cycle.
REQ-017 SHALL keep fill at W after a match in overlap mode (ovl=1), so the tail bits count toward the next match.
REQ-018 SHALL clear fill to 0 after a match in non-overlap mode (ovl=0), so no matched bit is reused.
REQ-019 SHALL hold history, fill and pattern unchanged while in_valid=0; out SHALL be 0 in the following cycle.
REQ-020 SHALL sample ovl on every accepted bit; a change SHALL take effect on the next accepted bit.
REQ-021 SHALL, on pat_load=1, load the pattern from pat_in, clear fill and history, and force out to 0 next cycle; any bit accepted in the same cycle SHALL be discarded and SHALL NOT be matched.
REQ-022 SHALL increment match_cnt by 1 per match, saturating at 2^CW-1.
REQ-023 SHALL give cnt_clr priority over a same-cycle increment: match_cnt becomes 0, and out still pulses for that match.

Reset
REQ-024 SHALL, while rst=1, set pattern to PAT_RST, history to 0, fill to 0, out to 0 and match_cnt to 0; rst SHALL override pat_load, in_valid and cnt_clr.
REQ-025 SHALL lose a partially received sequence on reset; bits accepted before reset SHALL never contribute to a match.

Configuration
REQ-026 SHALL compile the match_cnt port, the counter and cnt_clr only when SEQ_DET_CNT_EN is defined; without SEQ_DET_CNT_EN those ports and the counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 SHALL place the overlap/non-overlap mode encoding and the default W, PAT_RST and CW constants in the shared package seq_det_pkg.
REQ-028 SHALL implement history and fill tracking in one sub-module, seq_det_shreg; compare, output and counter logic SHALL live in seq_det_param.

Verification
REQ-029 SHALL cover: default pattern, ovl=1, accepted bits 1,0,1,1,0,1,1 -> out pulses after bit 4 and after bit 7; match_cnt=2.
REQ-030 SHALL cover: the same stream with ovl=0 -> a single pulse after bit 4; match_cnt=1.
REQ-031 SHALL cover: bits 1,0,1, then in_valid=0 for 3 cycles, then bit 1 -> one pulse only, in the cycle after the last bit.
REQ-032 SHALL cover: bits 1,0,1, then pat_load with pat_in=4'b0110, then bits 0,1,1,0 -> no pulse before the 4th post-load bit, then one pulse.
REQ-033 SHALL cover: CW=2 with ovl=1 and stream 1011011011011 -> match_cnt reads 1,2,3,3; then cnt_clr on a match cycle -> match_cnt=0 and out=1.
REQ-034 SHALL cover: bits 1,0,1, then rst for 1 cycle, then bit 1 -> no pulse; all outputs 0 in the cycle after rst.
